// File: rtl/ftoi_pipe.sv
// Two-stage float32 -> int32 converter with truncation toward zero and saturation.
// S1 classifies the operand and picks a shift amount; S2 shifts, negates and registers the result.
module ftoi_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] x,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] y,
  output logic        ovf,
  output logic        inexact,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [2:0] {
    C_SMALL,
    C_RSH,
    C_LSH,
    C_SAT,
    C_MIN
  } cls_t;

  logic [7:0]  w_e;
  logic [22:0] w_m;
  logic        w_sign;
  cls_t        w_cls;
  logic [4:0]  w_shamt;
  logic        w_s2_load;

  logic        r_s1_valid;
  cls_t        r_s1_cls;
  logic        r_s1_sign;
  logic [23:0] r_s1_sig;
  logic [4:0]  r_s1_shamt;
  logic        r_s1_tiny_inexact;

  logic        r_s2_valid;
  logic [31:0] r_y;
  logic        r_ovf;
  logic        r_inexact;

  assign w_e = x[30:23];
  assign w_m = x[22:0];

  assign w_s2_load = !r_s2_valid || out_ready;
  assign in_ready  = !r_s1_valid || w_s2_load;

  // NaN saturates positive whatever its sign bit, so the sign is forced here.
  always_comb begin
    w_cls   = C_SMALL;
    w_shamt = 5'd0;
    w_sign  = x[31];
    if (w_e == 8'hFF && w_m != 23'd0) begin
      w_cls  = C_SAT;
      w_sign = 1'b0;
    end else if (w_e < 8'd127) begin
      w_cls = C_SMALL;
    end else if (w_e <= 8'd150) begin
      w_cls   = C_RSH;
      w_shamt = 5'(8'd150 - w_e);
    end else if (w_e <= 8'd157) begin
      w_cls   = C_LSH;
      w_shamt = 5'(w_e - 8'd150);
    end else if (x == 32'hCF00_0000) begin
      w_cls = C_MIN;
    end else begin
      w_cls = C_SAT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid        <= 1'b0;
      r_s1_cls          <= C_SMALL;
      r_s1_sign         <= 1'b0;
      r_s1_sig          <= 24'd0;
      r_s1_shamt        <= 5'd0;
      r_s1_tiny_inexact <= 1'b0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_cls          <= w_cls;
        r_s1_sign         <= w_sign;
        r_s1_sig          <= {1'b1, w_m};
        r_s1_shamt        <= w_shamt;
        r_s1_tiny_inexact <= |x[30:0];
      end
    end
  end

  logic [31:0] w_ext;
  logic [31:0] w_mask;
  logic [31:0] w_mag;
  logic [31:0] w_res;
  logic        w_ovf;
  logic        w_inexact;

  assign w_ext  = {8'd0, r_s1_sig};
  assign w_mask = (32'd1 << r_s1_shamt) - 32'd1;

  always_comb begin
    w_mag     = 32'd0;
    w_res     = 32'd0;
    w_ovf     = 1'b0;
    w_inexact = 1'b0;
    case (r_s1_cls)
      C_SMALL: w_inexact = r_s1_tiny_inexact;
      C_RSH: begin
        w_mag     = w_ext >> r_s1_shamt;
        w_inexact = |(w_ext & w_mask);
        w_res     = r_s1_sign ? (32'd0 - w_mag) : w_mag;
      end
      C_LSH: begin
        w_mag = w_ext << r_s1_shamt;
        w_res = r_s1_sign ? (32'd0 - w_mag) : w_mag;
      end
      C_MIN: w_res = 32'h8000_0000;
      C_SAT: begin
        w_res = r_s1_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
        w_ovf = 1'b1;
      end
      default: w_res = 32'd0;
    endcase
  end

  // Output registers only move when a new result enters, so they hold under stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_y        <= 32'd0;
      r_ovf      <= 1'b0;
      r_inexact  <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_y       <= w_res;
        r_ovf     <= w_ovf;
        r_inexact <= w_inexact;
      end
    end
  end

  assign y         = r_y;
  assign ovf       = r_ovf;
  assign inexact   = r_inexact;
  assign out_valid = r_s2_valid;

endmodule

// File: tb/tb_ftoi_pipe.sv
// Scoreboard bench for ftoi_pipe: a behavioural integer-range model predicts each result at
// acceptance; results are popped and compared at delivery, plus directed latency/stall/reset checks.
module tb_ftoi_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] x;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] y;
  logic        ovf;
  logic        inexact;
  logic        out_valid;
  logic        out_ready;

  int n_tests = 0;
  int n_fail  = 0;
  logic [33:0] sb[$];
  bit rand_done = 1'b0;

  always #5 clk = ~clk;

  ftoi_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .x         (x),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y         (y),
    .ovf       (ovf),
    .inexact   (inexact),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: build the exact magnitude in 64 bits, then range-check it as an integer.
  task automatic model(input logic [31:0] v, output logic [31:0] ey, output logic eo, output logic ei);
    logic        s;
    int          e;
    longint      sig;
    longint      mag;
    s   = v[31];
    e   = int'(v[30:23]);
    sig = longint'({1'b1, v[22:0]});
    ey  = 32'd0;
    eo  = 1'b0;
    ei  = 1'b0;
    if (e == 255 && v[22:0] != 23'd0) begin
      ey = 32'h7FFF_FFFF;
      eo = 1'b1;
    end else if (e < 127) begin
      ei = (v[30:0] != 31'd0);
    end else if (e > 158) begin
      ey = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
      eo = 1'b1;
    end else begin
      if (e >= 150) begin
        mag = sig << (e - 150);
      end else begin
        mag = sig >> (150 - e);
        ei  = ((mag << (150 - e)) != sig);
      end
      if ((!s && mag >= 64'sd2147483648) || (s && mag > 64'sd2147483648)) begin
        ey = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
        eo = 1'b1;
        ei = 1'b0;
      end else begin
        ey = s ? 32'(-mag) : 32'(mag);
      end
    end
  endtask

  always @(negedge clk) begin
    logic [33:0] ent;
    logic [31:0] ey;
    logic        eo;
    logic        ei;
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 32'd1, 32'd0);
        end else begin
          ent = sb.pop_front();
          chk("y", y, ent[31:0]);
          chk("ovf", {31'd0, ovf}, {31'd0, ent[32]});
          chk("inexact", {31'd0, inexact}, {31'd0, ent[33]});
        end
      end
      if (in_valid && in_ready) begin
        model(x, ey, eo, ei);
        sb.push_back({ei, eo, ey});
      end
    end
  end

  task automatic send(input logic [31:0] v);
    bit ok;
    ok       = 1'b0;
    x        = v;
    in_valid = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_val();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0: r[30:23] = 8'($urandom_range(120, 160));
      1: r[30:23] = 8'($urandom_range(148, 159));
      default: ;
    endcase
    return r;
  endfunction

  localparam int N_DIR = 24;
  logic [31:0] dir_vals [N_DIR] = '{
    32'h4040_0000, 32'hC148_0000, 32'hC140_0000, 32'h4F00_0000,
    32'hCF00_0000, 32'h7FC0_0000, 32'h3F00_0000, 32'h437F_0000,
    32'h8000_0000, 32'h0000_0000, 32'h0000_0001, 32'h7F80_0000,
    32'hFF80_0000, 32'hFFC0_0000, 32'h4EFF_FFFF, 32'hCEFF_FFFF,
    32'h3F80_0000, 32'h4B7F_FFFF, 32'h4B80_0000, 32'hCF00_0001,
    32'h3FFF_FFFF, 32'hBF7F_FFFF, 32'hCB7F_FFFF, 32'h4B00_0001
  };

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    x         = 32'd0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_y", y, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_inexact", {31'd0, inexact}, 32'd0);
    @(posedge clk);
    #1;

    // latency: 3.0 accepted, visible two cycles later
    x        = 32'h4040_0000;
    in_valid = 1'b1;
    @(negedge clk);
    chk("lat_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("lat_cycle1", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("lat_cycle2", {31'd0, out_valid}, 32'd1);
    chk("lat_y", y, 32'd3);
    @(posedge clk);
    #1;

    foreach (dir_vals[i]) send(dir_vals[i]);
    idle(4);

    // stall: two accepts fill the pipe, output holds 1
    out_ready = 1'b0;
    send(32'h3F80_0000);
    send(32'h4000_0000);
    x        = 32'h4040_0000;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_hold_y", y, 32'd1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(32'h4040_0000);
    send(32'h4080_0000);
    idle(4);

    // reset with both stages full and an operand offered
    out_ready = 1'b0;
    send(32'h4120_0000);
    send(32'h4130_0000);
    x        = 32'h4140_0000;
    in_valid = 1'b1;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_y", y, 32'd0);
    chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    idle(10);
    @(negedge clk);
    chk("rst_no_stale", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;

    // random traffic with random backpressure
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
          send(rand_val());
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    for (int i = 0; i < 1000 && sb.size() != 0; i++) idle(1);
    chk("drain", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ftoi_pipe.md
FTOI_PIPE -- requirements
Module: ftoi_pipe

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 The block SHALL have the port x, input, 32 bits: IEEE-754 single-precision operand, normally the output of the floor stage.
REQ-004 The block SHALL have the port in_valid, input, 1 bit: x is valid this cycle.
REQ-005 The block SHALL have the port in_ready, output, 1 bit: the block accepts x this cycle.
REQ-006 The block SHALL have the port y, output, 32 bits: signed two's-complement int32 result.
REQ-007 The block SHALL have the port ovf, output, 1 bit: the result was saturated (out of range, Inf or NaN).
REQ-008 The block SHALL have the port inexact, output, 1 bit: nonzero fraction bits were discarded.
REQ-009 The block SHALL have the port out_valid, output, 1 bit: y, ovf and inexact are valid.
REQ-010 The block SHALL have the port out_ready, input, 1 bit: the consumer accepts the result this cycle.

Function
REQ-011 The block SHALL accept an operand on a cycle where in_valid=1 and in_ready=1, and SHALL deliver a result on a cycle where out_valid=1 and out_ready=1.
REQ-012 The block SHALL be a 2-stage pipeline (S1: decode and shift amount; S2: shift, negate, output register), each stage with its own valid bit.
REQ-013 Without stall, a result SHALL appear with out_valid=1 exactly 2 cycles after acceptance.
REQ-014 Sustained throughput SHALL be 1 operand per cycle.
REQ-015 S2 SHALL load when S2 is empty or out_ready=1.
REQ-016 S1 SHALL advance into S2 under the condition of REQ-015.
REQ-017 in_ready SHALL equal (!S1.valid || S2 will load this cycle), computed combinationally.
REQ-018 While out_valid=1 and out_ready=0, y, ovf and inexact SHALL hold stable.
REQ-019 No operand SHALL be dropped, duplicated or reordered under any stall pattern.
REQ-020 Decode SHALL use s=x[31], e=x[30:23], m=x[22:0], and significand {1,m} (24 bits).
REQ-021 If e<127 (|x|<1, including zero and denormals), y SHALL be 0, ovf=0, and inexact=1 exactly when x[30:0]!=0.
REQ-022 If 127<=e<=150, magnitude SHALL be {1,m}>>(150-e), truncated toward zero, and inexact SHALL be 1 if any shifted-out bit is 1.
REQ-023 If 151<=e<=157, magnitude SHALL be {1,m}<<(e-150), with inexact=0.
REQ-024 If e>=158 and x is exactly 0xCF000000 (-2^31), y SHALL be 0x80000000 with ovf=0.
REQ-025 If e>=158 for any other value, including ±Inf, y SHALL be 0x7FFFFFFF when s=0 and 0x80000000 when s=1, with ovf=1 and inexact=0.
REQ-026 For NaN (e=255, m!=0), y SHALL be 0x7FFFFFFF with ovf=1, regardless of sign.
REQ-027 For s=1 in the non-saturated cases, y SHALL be the two's-complement negation of the magnitude, and -0.0 SHALL give y=0.
REQ-028 The magnitude datapath SHALL be 32 bits wide, with no intermediate truncation before the negation.
REQ-029 Simultaneous accept and deliver in one cycle SHALL both take effect.

Reset
REQ-030 When rst=1 at a rising edge, both stage valid bits SHALL clear, so that out_valid=0 and, on the next cycle, in_ready=1.
REQ-031 y, ovf and inexact SHALL reset to 0.
REQ-032 Reset SHALL take priority over every handshake; an operand accepted in the same cycle as rst=1 SHALL be discarded.
REQ-033 In-flight operands SHALL be discarded when reset is asserted mid-operation, and no result for them SHALL ever appear.

Verification
REQ-034 Scenario: x=0x40400000 (3.0), out_ready=1 -> 2 cycles later y=0x00000003, ovf=0, inexact=0.
REQ-035 Scenario: x=0xC1480000 (-12.5) -> y=0xFFFFFFF4, inexact=1; then x=0xC1400000 (-12.0) -> y=0xFFFFFFF4, inexact=0.
REQ-036 Scenario: x=0x4F000000 (2^31) -> y=0x7FFFFFFF, ovf=1; x=0xCF000000 -> y=0x80000000, ovf=0; x=0x7FC00000 (NaN) -> y=0x7FFFFFFF, ovf=1.
REQ-037 Scenario: x=0x3F000000 (0.5) -> y=0, inexact=1; x=0x437F0000 (255.0) -> y=0x000000FF.
REQ-038 Scenario: stream 1.0, 2.0, 3.0, 4.0 back-to-back with out_ready=0 for 4 cycles -> in_ready=0 after 2 accepts, y holds 1 while stalled, then results 1, 2, 3, 4 in order after out_ready=1.
REQ-039 Scenario: rst=1 with both stages full -> next cycle out_valid=0, y=0, in_ready=1, and no stale result appears afterwards.
